// File: rtl/byte_ram_dp_pkg.sv
// Shared types and helpers for the byte-enabled dual-port RAM: sequencer
// states, lane count and the byte-merge used by the collision bypass.
package byte_ram_dp_pkg;

  typedef enum logic {CLEAR, RUN} state_t;

  localparam int BYTE_WIDTH     = 8;
  localparam int MAX_DATA_WIDTH = 256;
  localparam int MAX_NB         = MAX_DATA_WIDTH / BYTE_WIDTH;

  function automatic int lanes_of(input int data_width);
    return data_width / BYTE_WIDTH;
  endfunction

  // Callers size-cast their words to MAX_DATA_WIDTH and truncate the result back.
  function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [MAX_NB-1:0]         be
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int i = 0; i < MAX_NB; i++) begin
      if (be[i]) merged[BYTE_WIDTH*i +: BYTE_WIDTH] = new_word[BYTE_WIDTH*i +: BYTE_WIDTH];
    end
    return merged;
  endfunction

endpackage

// File: rtl/byte_ram_dp_lane.sv
// One byte lane of the RAM: 8-bit wide, DEPTH entries, one write port and
// two asynchronous read ports (port A and port B of the top).
module ram_lane
  import byte_ram_dp_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [BYTE_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr_a,
  input  logic [ADDR_WIDTH-1:0] raddr_b,
  output logic [BYTE_WIDTH-1:0] rdata_a,
  output logic [BYTE_WIDTH-1:0] rdata_b
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [BYTE_WIDTH-1:0] mem [DEPTH];

  // NOTE: the array has no reset so it maps onto RAM primitives; the clear
  // sweep in the top is the only thing that initialises it. Sequential state
  // always uses <= so every reader sees the pre-edge value.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/byte_ram_dp.sv
// Dual-port word RAM with per-byte write enables, a post-reset clear sweep
// and write-first bypass on the read-only port B.
module byte_ram_dp
  import byte_ram_dp_pkg::*;
#(
  parameter int                    DATA_WIDTH     = 16,
  parameter int                    ADDR_WIDTH     = 10,
  parameter bit                    CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE    = '0,
  localparam int                   NB             = lanes_of(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  resetn,
  output logic                  ready,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  input  logic [NB-1:0]         a_be,
  output logic [DATA_WIDTH-1:0] a_dout,
  output logic                  a_valid,
  input  logic                  b_req,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  output logic [DATA_WIDTH-1:0] b_dout,
  output logic                  b_valid
);

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] clr_cnt, cnt_next;
  logic [NB-1:0]         lane_we;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] a_word, b_word, b_merged;
  logic                  a_wr, a_rd, b_rd, b_hit;

  // Requests are only honoured once ready is up, which also covers the
  // first cycle after reset when the sweep is disabled.
  assign a_wr  = ready & a_req & a_we;
  assign a_rd  = ready & a_req & ~a_we;
  assign b_rd  = ready & b_req;
  assign b_hit = a_wr & (b_addr == a_addr);

  assign b_merged = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(b_word),
                                           MAX_DATA_WIDTH'(a_din),
                                           MAX_NB'(a_be)));

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path can leave it unassigned and infer a latch.
    state_next = state;
    cnt_next   = clr_cnt;
    if (state == CLEAR) begin
      cnt_next = clr_cnt + 1'b1;
      if (&clr_cnt) state_next = RUN;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= CLEAR_ON_RESET ? CLEAR : RUN;
      clr_cnt <= '0;
      ready   <= 1'b0;
    end else begin
      state   <= state_next;
      clr_cnt <= cnt_next;
      ready   <= (state_next == RUN);
    end
  end

  always_comb begin
    lane_we = '0;
    wr_addr = a_addr;
    wr_data = a_din;
    if (state == CLEAR) begin
      lane_we = '1;
      wr_addr = clr_cnt;
      wr_data = CLEAR_VALUE;
    end else if (a_wr) begin
      lane_we = a_be;
    end
  end

  for (genvar i = 0; i < NB; i++) begin : g_lane
    ram_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
      .clk     (clk),
      .we      (lane_we[i]),
      .waddr   (wr_addr),
      .wdata   (wr_data[BYTE_WIDTH*i +: BYTE_WIDTH]),
      .raddr_a (a_addr),
      .raddr_b (b_addr),
      .rdata_a (a_word[BYTE_WIDTH*i +: BYTE_WIDTH]),
      .rdata_b (b_word[BYTE_WIDTH*i +: BYTE_WIDTH])
    );
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      a_dout  <= '0;
      a_valid <= 1'b0;
      b_dout  <= '0;
      b_valid <= 1'b0;
    end else begin
      a_valid <= a_rd;
      b_valid <= b_rd;
      if (a_rd) a_dout <= a_word;
      if (b_rd) b_dout <= b_hit ? b_merged : b_word;
    end
  end

endmodule

// File: tb/tb_byte_ram_dp.sv
// Bench for byte_ram_dp: a 16-bit instance with a 0xA5A5 clear sweep and a
// 32-bit instance without one, each tracked by a word-level model.
module tb_byte_ram_dp;
  import byte_ram_dp_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 16-bit instance, DEPTH 16, sweep enabled
  logic        rst16 = 1'b1, ready16, a16_req = 0, a16_we = 0, a16_valid, b16_req = 0, b16_valid;
  logic [3:0]  a16_addr = '0, b16_addr = '0;
  logic [15:0] a16_din = '0, a16_dout, b16_dout;
  logic [1:0]  a16_be = '0;

  byte_ram_dp #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(16'hA5A5)) dut16 (
    .clk(clk), .resetn(rst16), .ready(ready16),
    .a_req(a16_req), .a_we(a16_we), .a_addr(a16_addr), .a_din(a16_din), .a_be(a16_be),
    .a_dout(a16_dout), .a_valid(a16_valid),
    .b_req(b16_req), .b_addr(b16_addr), .b_dout(b16_dout), .b_valid(b16_valid)
  );

  // 32-bit instance, DEPTH 16, no sweep
  logic        rst32 = 1'b1, ready32, a32_req = 0, a32_we = 0, a32_valid, b32_req = 0, b32_valid;
  logic [3:0]  a32_addr = '0, b32_addr = '0;
  logic [31:0] a32_din = '0, a32_dout, b32_dout;
  logic [3:0]  a32_be = '0;

  byte_ram_dp #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .CLEAR_ON_RESET(1'b0), .CLEAR_VALUE(32'h0)) dut32 (
    .clk(clk), .resetn(rst32), .ready(ready32),
    .a_req(a32_req), .a_we(a32_we), .a_addr(a32_addr), .a_din(a32_din), .a_be(a32_be),
    .a_dout(a32_dout), .a_valid(a32_valid),
    .b_req(b32_req), .b_addr(b32_addr), .b_dout(b32_dout), .b_valid(b32_valid)
  );

  function automatic logic [15:0] merge16(input logic [15:0] o, input logic [15:0] n, input logic [1:0] be);
    return 16'(byte_merge(MAX_DATA_WIDTH'(o), MAX_DATA_WIDTH'(n), MAX_NB'(be)));
  endfunction

  function automatic logic [31:0] merge32(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    return 32'(byte_merge(MAX_DATA_WIDTH'(o), MAX_DATA_WIDTH'(n), MAX_NB'(be)));
  endfunction

  // Word-level model: the array becomes all-0xA5A5 once 16 edges have passed
  // since release; accesses count only while ready; port B sees port A's bytes.
  logic [15:0] m16 [16];
  int          edges16 = 0;
  logic        e16_ready = 0, e16_av = 0, e16_bv = 0;
  logic [15:0] e16_ad = '0, e16_bd = '0;

  always @(posedge clk or negedge rst16) begin
    if (!rst16) begin
      edges16 <= 0; e16_ready <= 0; e16_av <= 0; e16_bv <= 0; e16_ad <= '0; e16_bd <= '0;
    end else begin
      edges16   <= edges16 + 1;
      e16_ready <= (edges16 + 1 >= 16);
      if (edges16 + 1 == 16) for (int k = 0; k < 16; k++) m16[k] <= 16'hA5A5;
      e16_av <= e16_ready && a16_req && !a16_we;
      e16_bv <= e16_ready && b16_req;
      if (e16_ready && a16_req && a16_we) m16[a16_addr] <= merge16(m16[a16_addr], a16_din, a16_be);
      if (e16_ready && a16_req && !a16_we) e16_ad <= m16[a16_addr];
      if (e16_ready && b16_req)
        e16_bd <= (a16_req && a16_we && b16_addr == a16_addr) ? merge16(m16[b16_addr], a16_din, a16_be)
                                                              : m16[b16_addr];
    end
  end

  logic [31:0] m32 [16];
  logic        e32_ready = 0, e32_av = 0, e32_bv = 0;
  logic [31:0] e32_ad = '0, e32_bd = '0;

  always @(posedge clk or negedge rst32) begin
    if (!rst32) begin
      e32_ready <= 0; e32_av <= 0; e32_bv <= 0; e32_ad <= '0; e32_bd <= '0;
    end else begin
      e32_ready <= 1'b1;
      e32_av <= e32_ready && a32_req && !a32_we;
      e32_bv <= e32_ready && b32_req;
      if (e32_ready && a32_req && a32_we) m32[a32_addr] <= merge32(m32[a32_addr], a32_din, a32_be);
      if (e32_ready && a32_req && !a32_we) e32_ad <= m32[a32_addr];
      if (e32_ready && b32_req)
        e32_bd <= (a32_req && a32_we && b32_addr == a32_addr) ? merge32(m32[b32_addr], a32_din, a32_be)
                                                              : m32[b32_addr];
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      check("ready16",   32'(ready16),   32'(e16_ready));
      check("a_valid16", 32'(a16_valid), 32'(e16_av));
      check("a_dout16",  32'(a16_dout),  32'(e16_ad));
      check("b_valid16", 32'(b16_valid), 32'(e16_bv));
      check("b_dout16",  32'(b16_dout),  32'(e16_bd));
      check("ready32",   32'(ready32),   32'(e32_ready));
      check("a_valid32", 32'(a32_valid), 32'(e32_av));
      check("a_dout32",  a32_dout,       e32_ad);
      check("b_valid32", 32'(b32_valid), 32'(e32_bv));
      check("b_dout32",  b32_dout,       e32_bd);
    end
  end

  task automatic a16_drive(input logic req, input logic we, input logic [3:0] addr,
                           input logic [15:0] din, input logic [1:0] be);
    a16_req = req; a16_we = we; a16_addr = addr; a16_din = din; a16_be = be;
  endtask

  task automatic a32_drive(input logic req, input logic we, input logic [3:0] addr,
                           input logic [31:0] din, input logic [3:0] be);
    a32_req = req; a32_we = we; a32_addr = addr; a32_din = din; a32_be = be;
  endtask

  logic [15:0] t4_val [3] = '{16'h1000, 16'h1111, 16'h2222};

  initial begin
    #1;
    rst16 = 1'b0;
    rst32 = 1'b0;
    #1;
    cmp_on = 1'b1;
    check("reset_ready16", 32'(ready16), 32'h0);
    check("reset_a_dout16", 32'(a16_dout), 32'h0);
    tick();
    tick();

    // 1: sweep takes exactly 16 edges, then every word reads back 0xA5A5
    rst16 = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      tick();
      if (n == 15) check("t1_ready_edge15", 32'(ready16), 32'h0);
      if (n == 16) check("t1_ready_edge16", 32'(ready16), 32'h1);
    end
    for (int k = 0; k < 16; k++) begin
      a16_drive(1'b1, 1'b0, 4'(k), 16'h0, 2'b00);
      tick();
      check("t1_clear_read", 32'(a16_dout), 32'h0000A5A5);
    end
    a16_drive(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
    tick();

    // 2: partial byte write then read
    a16_drive(1'b1, 1'b1, 4'd3, 16'h1234, 2'b11);
    tick();
    a16_drive(1'b1, 1'b1, 4'd3, 16'hABCD, 2'b10);
    tick();
    a16_drive(1'b1, 1'b0, 4'd3, 16'h0, 2'b00);
    tick();
    check("t2_a_valid", 32'(a16_valid), 32'h1);
    check("t2_a_dout", 32'(a16_dout), 32'h0000AB34);
    a16_drive(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
    tick();
    check("t2_a_valid_drop", 32'(a16_valid), 32'h0);
    check("t2_a_dout_hold", 32'(a16_dout), 32'h0000AB34);

    // 3: collision bypass on port B
    a16_drive(1'b1, 1'b1, 4'd7, 16'h0000, 2'b11);
    tick();
    a16_drive(1'b1, 1'b1, 4'd7, 16'hBEEF, 2'b01);
    b16_req = 1'b1; b16_addr = 4'd7;
    tick();
    check("t3_b_valid", 32'(b16_valid), 32'h1);
    check("t3_b_bypass", 32'(b16_dout), 32'h000000EF);
    a16_drive(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
    tick();
    check("t3_b_reread", 32'(b16_dout), 32'h000000EF);
    b16_req = 1'b0;

    // 4: back-to-back reads on both ports
    for (int i = 0; i < 3; i++) begin
      a16_drive(1'b1, 1'b1, 4'(i), t4_val[i], 2'b11);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      a16_drive(1'b1, 1'b0, 4'(i), 16'h0, 2'b00);
      b16_req = 1'b1; b16_addr = 4'(2 - i);
      tick();
      check("t4_a_valid", 32'(a16_valid), 32'h1);
      check("t4_a_dout", 32'(a16_dout), 32'(t4_val[i]));
      check("t4_b_valid", 32'(b16_valid), 32'h1);
      check("t4_b_dout", 32'(b16_dout), 32'(t4_val[2 - i]));
    end
    a16_drive(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);
    b16_req = 1'b0;
    tick();
    check("t4_valids_drop", 32'({a16_valid, b16_valid}), 32'h0);

    // 5: reset mid-sweep restarts the sweep; port B requests are ignored meanwhile
    rst16 = 1'b0;
    #1;
    check("t5_async_ready", 32'(ready16), 32'h0);
    check("t5_async_dout", 32'(a16_dout), 32'h0);
    tick();
    rst16 = 1'b1;
    b16_req = 1'b1; b16_addr = 4'd7;
    for (int n = 0; n < 5; n++) tick();
    rst16 = 1'b0;
    tick();
    rst16 = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      tick();
      check("t5_no_b_valid", 32'(b16_valid), 32'h0);
      if (n == 15) check("t5_ready_edge15", 32'(ready16), 32'h0);
      if (n == 16) check("t5_ready_edge16", 32'(ready16), 32'h1);
    end
    b16_req = 1'b0;
    a16_drive(1'b1, 1'b0, 4'd3, 16'h0, 2'b00);
    tick();
    check("t5_recleared", 32'(a16_dout), 32'h0000A5A5);
    a16_drive(1'b0, 1'b0, 4'd0, 16'h0, 2'b00);

    // 6: 32-bit instance without sweep
    rst32 = 1'b1;
    check("t6_ready_before_edge", 32'(ready32), 32'h0);
    tick();
    check("t6_ready_first_edge", 32'(ready32), 32'h1);
    a32_drive(1'b1, 1'b1, 4'd5, 32'hFFFFFFFF, 4'b1111);
    tick();
    a32_drive(1'b1, 1'b1, 4'd5, 32'h11223344, 4'b0101);
    tick();
    a32_drive(1'b1, 1'b0, 4'd5, 32'h0, 4'b0000);
    b32_req = 1'b1; b32_addr = 4'd5;
    tick();
    check("t6_a_dout", a32_dout, 32'hFF22FF44);
    check("t6_b_dout", b32_dout, 32'hFF22FF44);
    a32_drive(1'b0, 1'b0, 4'd0, 32'h0, 4'b0000);
    b32_req = 1'b0;
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/byte_ram_dp.md
Name: byte_ram_dp

Overview:
- Parametrised dual-port word RAM with per-byte write enables.
- Port A: read/write, for the CPU. Port B: read-only, for video/scan-out.
- After reset, a built-in clear sequencer optionally fills the whole array with a fixed value before the block accepts any access.
- Port B has write-first collision bypass, so scan-out never sees stale bytes that port A is writing in the same cycle.

Parameters:
- DATA_WIDTH, 16, word width in bits; must be a multiple of 8. NB = DATA_WIDTH/8 byte lanes.
- ADDR_WIDTH, 10, word address width; DEPTH = 2**ADDR_WIDTH.
- CLEAR_ON_RESET, 1, 1 = sweep-clear the array after reset; 0 = skip the sweep.
- CLEAR_VALUE, 0, DATA_WIDTH-bit word written to every location during the sweep.

Ports:
- clk, in, 1, single clock; all logic samples on the rising edge.
- resetn, in, 1, asynchronous active-low reset.
- ready, out, 1, high when both ports accept requests.
- a_req, in, 1, port A access request.
- a_we, in, 1, 1 = write, 0 = read.
- a_addr, in, ADDR_WIDTH, port A word address.
- a_din, in, DATA_WIDTH, port A write data.
- a_be, in, NB, byte enables; bit i gates a_din[8i+7:8i].
- a_dout, out, DATA_WIDTH, port A registered read data.
- a_valid, out, 1, one-cycle pulse marking a_dout valid.
- b_req, in, 1, port B read request.
- b_addr, in, ADDR_WIDTH, port B word address.
- b_dout, out, DATA_WIDTH, port B registered read data.
- b_valid, out, 1, one-cycle pulse marking b_dout valid.

Behaviour:
- Reset (resetn low, asynchronous): ready=0, a_valid=0, b_valid=0, a_dout=0, b_dout=0, clear counter=0.
  - State = CLEAR if CLEAR_ON_RESET=1, else RUN.
  - The array itself is not reset; only the sweep modifies it.
- State CLEAR:
  - Each edge writes CLEAR_VALUE to all lanes at the counter address, then increments the counter.
  - The edge that writes DEPTH-1 moves the state to RUN. ready rises after exactly DEPTH edges following reset release.
  - a_req and b_req are ignored: no writes, no valid pulses.
- State RUN: ready=1, registered.
  - With CLEAR_ON_RESET=0, ready is 1 from the first edge after reset release.
- Port A write (a_req & a_we): writes only the lanes with a_be set. a_valid stays 0. a_be=0 is a legal no-op.
- Port A read (a_req & ~a_we): a_dout = mem[a_addr] on the next edge, with a_valid=1 for that one cycle. Latency is 1 cycle.
  - a_dout holds its value when no read is issued; a_valid returns to 0.
- Port B read (b_req): b_dout = mem[b_addr] after 1 cycle, with b_valid=1 for that one cycle.
- Collision (same cycle: port A write and b_req, b_addr == a_addr):
  - b_dout returns the merged word: a_din bytes where a_be is set, old bytes elsewhere (write-first).
  - No other collision case exists, since port B never writes.
- Both ports may issue every cycle; there are no stalls once in RUN.
- Reset mid-sweep or mid-access: outputs clear immediately and any in-flight read is dropped.
  - A CLEAR_ON_RESET sweep restarts from address 0.
  - A write on the edge coincident with resetn falling is not guaranteed.
- Addresses wrap naturally at the ADDR_WIDTH width; there are no out-of-range accesses.

Decomposition:
- Shared package:
  - state enum {CLEAR, RUN};
  - a function returning NB from DATA_WIDTH;
  - the byte-merge function (old word, new word, be) used by both the bypass path and the bench model.
- One natural sub-module: ram_lane, an 8-bit, DEPTH-entry, one write / two read-port bank.
  - byte_ram_dp instantiates NB lanes and adds the sequencer, the request muxing and the collision bypass.

Test Plan:
1. Reset release, CLEAR_ON_RESET=1, CLEAR_VALUE=16'hA5A5, ADDR_WIDTH=4 -> ready rises after exactly 16 edges; port A reads of addresses 0..15 all return 16'hA5A5.
2. Write 16'h1234 to address 3 with a_be=2'b11, then write 16'hABCD with a_be=2'b10, then read -> a_dout=16'hAB34 one cycle after the read request, with a_valid high for one cycle.
3. Same cycle: port A write 16'hBEEF with a_be=2'b01 to address 7 (old 16'h0000), b_req to address 7 -> b_dout=16'h00EF; the next port B read of address 7 returns 16'h00EF.
4. Back-to-back: port A reads addresses 0,1,2 while port B reads addresses 2,1,0 on consecutive cycles -> both valid streams are continuous and their data matches the model.
5. resetn pulsed low at sweep count 5 -> ready stays 0; the sweep restarts at 0 and ready rises DEPTH edges after the second release. A b_req issued during the sweep produces no b_valid.
6. CLEAR_ON_RESET=0, DATA_WIDTH=32 -> ready=1 on the first edge after reset. A 4-lane write of 32'h11223344 with a_be=4'b0101 to an address previously holding 32'hFFFFFFFF reads back 32'hFF22FF44.
